// File: rtl/stc_a_packer_if.sv
// Dense-row input stream for the A-tile packer.
// master = row producer, slave = packer.
interface stc_a_packer_if #(
    parameter int DW_MEM = 256
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DW_MEM-1:0] in_row;
    logic              in_last;

    modport master (
        output in_valid,
        output in_row,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_row,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/stc_a_packer.sv
// Sparse A-tile packer. Each dense row is scanned LANES elements per cycle.
// Nonzero elements are compacted into ascending slots together with their
// column index. The packed row is then presented for one EMIT cycle, along
// with CSR-style row pointer bookkeeping for the tile.
module stc_a_packer #(
    parameter int M       = 16,
    parameter int K       = 16,
    parameter int DW_MEM  = 256,
    parameter int DW_DATA = 16,
    parameter int DW_COL  = 4,
    parameter int DW_PTR  = 8,
    parameter int LANES   = 4
) (
    input  logic                clk,
    input  logic                reset,
    stc_a_packer_if.slave       in_bus,
    output logic                write_data_en,
    output logic                write_cidx_en,
    output logic [DW_MEM-1:0]   A_data_output,
    output logic [DW_MEM-1:0]   A_colidx_output,
    output logic [DW_COL-1:0]   idx,
    output logic [DW_PTR-1:0]   row_ptr,
    output logic [DW_COL:0]     row_nnz,
    output logic                tile_done,
    output logic [DW_PTR:0]     tile_nnz
);
    localparam int NSCAN = K / LANES;
    localparam int SCW   = (NSCAN > 1) ? $clog2(NSCAN) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

    state_t              state_reg, state_next;
    logic [DW_MEM-1:0]   row_reg;
    logic                last_reg;
    logic [SCW-1:0]      scan_cnt_reg;
    logic [DW_COL:0]     nnz_reg, nnz_next;
    logic [DW_DATA-1:0]  slot_data_reg [K];
    logic [DW_DATA-1:0]  slot_data_next [K];
    logic [DW_COL-1:0]   slot_col_reg [K];
    logic [DW_COL-1:0]   slot_col_next [K];
    logic [DW_COL-1:0]   row_cnt_reg;
    logic [DW_PTR-1:0]   tile_sum_reg;
    logic [DW_MEM-1:0]   data_out_reg, colidx_out_reg;
    logic [DW_COL-1:0]   idx_reg;
    logic [DW_PTR-1:0]   row_ptr_reg;
    logic [DW_COL:0]     row_nnz_reg;

    logic [DW_COL-1:0]   lane_col [LANES];
    logic [DW_DATA-1:0]  lane_elem [LANES];
    logic [K*DW_DATA-1:0] data_flat;
    logic [K*16-1:0]     colidx_flat;

    logic ready;
    logic accept;
    logic scan_last;
    logic in_emit;
    logic tile_end;

    assign ready           = (state_reg != SCAN);
    assign in_bus.in_ready = ready;
    assign accept          = in_bus.in_valid && ready;
    assign scan_last       = (scan_cnt_reg == SCW'(NSCAN - 1));
    assign in_emit         = (state_reg == EMIT);
    // A tile closes on an explicit last flag or when the row index saturates.
    assign tile_end        = last_reg || (idx_reg == DW_COL'(M - 1));

    // Lanes of the current scan beat: column index and element value.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_col[gi]  = DW_COL'(int'(scan_cnt_reg) * LANES + gi);
        assign lane_elem[gi] = row_reg[lane_col[gi]*DW_DATA +: DW_DATA];
    end

    // Flattened view of the slot buffer including this beat's writes.
    for (genvar gi = 0; gi < K; gi++) begin : g_flat
        assign data_flat[gi*DW_DATA +: DW_DATA] = slot_data_next[gi];
        assign colidx_flat[gi*16 +: 16]         = 16'(slot_col_next[gi]);
    end

    // Compact this beat's nonzeros into the next free slots, in column order.
    always_comb begin
        slot_data_next = slot_data_reg;
        slot_col_next  = slot_col_reg;
        nnz_next       = nnz_reg;
        if (state_reg == SCAN) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_elem[l] != '0) begin
                    slot_data_next[nnz_next[DW_COL-1:0]] = lane_elem[l];
                    slot_col_next[nnz_next[DW_COL-1:0]]  = lane_col[l];
                    nnz_next = nnz_next + (DW_COL+1)'(1);
                end
            end
        end
    end

    // Next-state logic: scan for NSCAN beats, emit once, chain directly if a row waits.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_bus.in_valid) state_next = SCAN;
            SCAN: if (scan_last) state_next = EMIT;
            EMIT: state_next = in_bus.in_valid ? SCAN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Row capture, slot buffer and scan counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_reg      <= '0;
            last_reg     <= 1'b0;
            scan_cnt_reg <= '0;
            nnz_reg      <= '0;
            for (int i = 0; i < K; i++) begin
                slot_data_reg[i] <= '0;
                slot_col_reg[i]  <= '0;
            end
        end else if (accept) begin
            row_reg      <= in_bus.in_row;
            last_reg     <= in_bus.in_last;
            scan_cnt_reg <= '0;
            nnz_reg      <= '0;
            for (int i = 0; i < K; i++) begin
                slot_data_reg[i] <= '0;
                slot_col_reg[i]  <= '0;
            end
        end else if (state_reg == SCAN) begin
            scan_cnt_reg  <= scan_cnt_reg + SCW'(1);
            nnz_reg       <= nnz_next;
            slot_data_reg <= slot_data_next;
            slot_col_reg  <= slot_col_next;
        end
    end

    // Output holding registers, loaded on the final scan beat so EMIT sees the packed row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_reg   <= '0;
            colidx_out_reg <= '0;
            idx_reg        <= '0;
            row_ptr_reg    <= '0;
            row_nnz_reg    <= '0;
        end else if ((state_reg == SCAN) && scan_last) begin
            data_out_reg   <= DW_MEM'(data_flat);
            colidx_out_reg <= DW_MEM'(colidx_flat);
            idx_reg        <= row_cnt_reg;
            row_ptr_reg    <= tile_sum_reg;
            row_nnz_reg    <= nnz_next;
        end
    end

    // Tile bookkeeping: advance row index and running sum as each row leaves EMIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_cnt_reg  <= '0;
            tile_sum_reg <= '0;
        end else if (in_emit) begin
            if (tile_end) begin
                row_cnt_reg  <= '0;
                tile_sum_reg <= '0;
            end else begin
                row_cnt_reg  <= row_cnt_reg + DW_COL'(1);
                tile_sum_reg <= tile_sum_reg + DW_PTR'(row_nnz_reg);
            end
        end
    end

    assign write_data_en   = in_emit;
    assign write_cidx_en   = in_emit;
    assign A_data_output   = data_out_reg;
    assign A_colidx_output = colidx_out_reg;
    assign idx             = idx_reg;
    assign row_ptr         = row_ptr_reg;
    assign row_nnz         = row_nnz_reg;
    assign tile_done       = in_emit && tile_end;
    assign tile_nnz        = (DW_PTR+1)'(row_ptr_reg) + (DW_PTR+1)'(row_nnz_reg);
endmodule
